// File: rtl/cpu_timing_pkg.sv
// Shared definitions for the CPU timing chain: sequencer states,
// default geometry of the sequence counter and a T-signal width helper.
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        INT   = 2'd3
    } state_e;

    localparam int SC_W_DEF      = 4;
    localparam int FETCH_LEN_DEF = 3;
    localparam int INT_LEN_DEF   = 3;

    // Number of one-hot timing lines produced by an sc_w-bit counter.
    function automatic int t_width(input int sc_w);
        return 1 << sc_w;
    endfunction

endpackage

// File: rtl/sc_decoder.sv
// Combinational SC_W-to-2**SC_W one-hot decoder with enable.
module sc_decoder #(
    parameter int SC_W = 4,
    parameter int T_W  = 16
) (
    input  logic            en,
    input  logic [SC_W-1:0] sel,
    output logic [T_W-1:0]  t
);

    // Drive exactly one line high for the selected count when enabled.
    always_comb begin
        t = '0;
        if (en) begin
            t[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// CPU timing sequencer: owns the sequence counter, produces T0..T(2**SC_W-1)
// and steps through fetch, execute and interrupt cycles.
// Optional macro SEQ_WATCHDOG_EN: an EXEC step reaching the counter maximum
// without sc_clr raises sticky err and drops back to IDLE instead of wrapping.
//
// Handshake: start and halt are levels, not pulses. start is accepted only in
// IDLE and only when halt is low; halt is accepted in any non-IDLE state and
// takes effect on the next edge. stall freezes counter and state for the cycle
// it is high and blanks the T signals; sc_clr is accepted only in EXEC on a
// cycle with neither halt nor stall, which is when instr_done pulses.
module timing_sequencer
    import cpu_timing_pkg::*;
#(
    parameter int SC_W      = SC_W_DEF,
    parameter int FETCH_LEN = FETCH_LEN_DEF,
    parameter int INT_LEN   = INT_LEN_DEF,
    parameter int T_W       = t_width(SC_W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt,
    input  logic            sc_clr,
    input  logic            stall,
    input  logic            ien,
    input  logic            int_req,
    output logic [SC_W-1:0] sc,
    output logic [T_W-1:0]  t_sig,
    output logic            run,
    output logic            r_flag,
    output logic            fetch,
    output logic            instr_done,
    output logic            int_ack,
    output logic            err,
    output state_e          state_dbg
);

    localparam logic [SC_W-1:0] FETCH_LAST = SC_W'(FETCH_LEN - 1);
    localparam logic [SC_W-1:0] INT_LAST   = SC_W'(INT_LEN - 1);
    localparam logic [SC_W-1:0] FETCH_END  = SC_W'(FETCH_LEN);
    localparam logic [SC_W-1:0] SC_MAX     = '1;

    state_e          state_q, state_nxt;
    logic [SC_W-1:0] sc_q, sc_nxt;
    logic            r_q, r_nxt;
`ifdef SEQ_WATCHDOG_EN
    logic            err_q, err_nxt;
`endif

    // State, counter and interrupt flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sc_q    <= '0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            sc_q    <= sc_nxt;
            r_q     <= r_nxt;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    // Sticky watchdog error, cleared by reset or an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next state and pulses; priority is halt > stall > sc_clr > increment.
    always_comb begin
        state_nxt  = state_q;
        sc_nxt     = sc_q;
        r_nxt      = r_q;
`ifdef SEQ_WATCHDOG_EN
        err_nxt    = err_q;
`endif
        instr_done = 1'b0;
        int_ack    = 1'b0;
        if (state_q == IDLE) begin
            sc_nxt = '0;
            if (start && !halt) begin
                state_nxt = FETCH;
`ifdef SEQ_WATCHDOG_EN
                err_nxt   = 1'b0;
`endif
            end
        end else if (halt) begin
            // r_flag survives a halt so a pending interrupt is still taken.
            state_nxt = IDLE;
            sc_nxt    = '0;
        end else if (!stall) begin
            case (state_q)
                FETCH: begin
                    sc_nxt = sc_q + 1'b1;
                    if (sc_q == FETCH_LAST) begin
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    if (ien && int_req) begin
                        r_nxt = 1'b1;
                    end
                    if (sc_clr) begin
                        instr_done = 1'b1;
                        sc_nxt     = '0;
                        state_nxt  = r_q ? INT : FETCH;
                    end else if (sc_q == SC_MAX) begin
`ifdef SEQ_WATCHDOG_EN
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
`endif
                        sc_nxt    = '0;
                    end else begin
                        sc_nxt = sc_q + 1'b1;
                    end
                end
                INT: begin
                    if (sc_q == INT_LAST) begin
                        int_ack   = 1'b1;
                        r_nxt     = 1'b0;
                        sc_nxt    = '0;
                        state_nxt = FETCH;
                    end else begin
                        sc_nxt = sc_q + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign run       = (state_q != IDLE);
    assign sc        = sc_q;
    assign r_flag    = r_q;
    assign fetch     = run && (state_q != INT) && (sc_q < FETCH_END);
    assign state_dbg = state_q;

    sc_decoder #(
        .SC_W (SC_W),
        .T_W  (T_W)
    ) u_dec (
        .en  (run && !stall),
        .sel (sc_q),
        .t   (t_sig)
    );

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: table of per-cycle vectors plus hand-written
// sequences for counter wrap / watchdog and asynchronous reset mid-INT.
module tb_timing_sequencer;
    import cpu_timing_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start, halt, sc_clr, stall, ien, int_req;
    logic [3:0]  sc;
    logic [15:0] t_sig;
    logic        run, r_flag, fetch, instr_done, int_ack, err;
    state_e      state_dbg;
    logic [25:0] obs;

    logic [25:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic        start;
        logic        halt;
        logic        sc_clr;
        logic        stall;
        logic        ien;
        logic        int_req;
        logic [25:0] exp;
    } vec_t;

    vec_t tbl[$];

    timing_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt       (halt),
        .sc_clr     (sc_clr),
        .stall      (stall),
        .ien        (ien),
        .int_req    (int_req),
        .sc         (sc),
        .t_sig      (t_sig),
        .run        (run),
        .r_flag     (r_flag),
        .fetch      (fetch),
        .instr_done (instr_done),
        .int_ack    (int_ack),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    assign obs = {sc, t_sig, run, r_flag, fetch, instr_done, int_ack, err};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observation word; T lines are one-hot on sc unless idle or stalled.
    function automatic logic [25:0] pack(input logic [3:0] s, input logic rn,
                                         input logic st, input logic r,
                                         input logic f, input logic d,
                                         input logic a, input logic e);
        logic [15:0] t;
        t = (rn && !st) ? (16'h0001 << s) : 16'h0000;
        return {s, t, rn, r, f, d, a, e};
    endfunction

    function automatic vec_t mk(input logic st, input logic hl, input logic cl,
                                input logic sl, input logic ie, input logic ir,
                                input logic [3:0] s, input logic rn, input logic r,
                                input logic f, input logic d, input logic a);
        vec_t v;
        v.start   = st;
        v.halt    = hl;
        v.sc_clr  = cl;
        v.stall   = sl;
        v.ien     = ie;
        v.int_req = ir;
        v.exp     = pack(s, rn, sl, r, f, d, a, 1'b0);
        return v;
    endfunction

    // Scoreboard compare of the current outputs against the oldest expectation.
    task automatic check(input string nm);
        logic [25:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", nm, obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s: got sc=%0d t=%h run=%b r=%b f=%b done=%b ack=%b err=%b, required sc=%0d t=%h run=%b r=%b f=%b done=%b ack=%b err=%b",
                         nm, obs[25:22], obs[21:6], obs[5], obs[4], obs[3], obs[2], obs[1], obs[0],
                         e[25:22], e[21:6], e[5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    endtask

    // Driver: apply one cycle of inputs, compare mid-cycle, advance past the edge.
    task automatic step(input vec_t v, input string nm);
        start   = v.start;
        halt    = v.halt;
        sc_clr  = v.sc_clr;
        stall   = v.stall;
        ien     = v.ien;
        int_req = v.int_req;
        exp_q.push_back(v.exp);
        #4;
        check(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start = 0; halt = 0; sc_clr = 0; stall = 0; ien = 0; int_req = 0;

        // Table: start, sc_clr at 5, stall at 3, interrupt cycle, halt at 7.
        //                st hl cl sl ie ir   sc rn r  f  d  a
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,  5, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,  4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  5, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,  6, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  2, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0));
        for (int k = 1; k <= 6; k++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'(k), 1, 0, (k < 3), 0, 0));
        end
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,  7, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0));

        // Reset state while rst_n is low.
        #3;
        exp_q.push_back(26'h0);
        check("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Counter runs to its maximum in EXEC with no sc_clr.
        for (int k = 1; k <= 15; k++) begin
            v = mk(0, 0, 0, 0, 0, 0, 4'(k), 1, 0, (k < 3), 0, 0);
            step(v, $sformatf("walk_sc%0d", k));
        end
`ifdef SEQ_WATCHDOG_EN
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.exp = pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(v, "watchdog_err");
`else
        v = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        step(v, "wrap_to_0");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halted_idle");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "restart");
`endif
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), "resume_fetch");

        // Enter INT, then drop rst_n between edges at INT sc=1.
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), "pre_int_f1");
        step(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0), "pre_int_f2");
        step(mk(0, 0, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0), "pre_int_irq");
        step(mk(0, 0, 1, 0, 0, 0, 4, 1, 1, 0, 1, 0), "pre_int_clr");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "int_sc0");
        exp_q.push_back(pack(4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        #2;
        check("int_sc1");
        rst_n = 1'b0;
        #1;
        exp_q.push_back(26'h0);
        check("async_reset_mid_int");
        @(posedge clk);
        #1;
        exp_q.push_back(26'h0);
        check("reset_held");
        rst_n = 1'b1;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
